// File: rtl/scan_mux_pkg.sv
// Shared constants and helpers for the scan_mux_n family.
// Imported by the round-robin search and by the top level.
package scan_mux_pkg;

   localparam logic MODE_MANUAL = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // Index width for n items, never below one bit, so a 1-entry case still has a port.
   function automatic int clog2_safe(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << r) < n) r++;
      end
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/mask_rr_next.sv
// Circular priority search: the next set mask bit after cur, wrapping to the lowest.
// The mask is doubled so that a single ascending priority encode covers the wrap.
module mask_rr_next
   import scan_mux_pkg::*;
#(
   parameter int N_CH  = 8,
   parameter int SEL_W = clog2_safe(N_CH)
) (
   input  logic [N_CH-1:0]  mask,
   input  logic [SEL_W-1:0] cur,
   output logic [SEL_W-1:0] nxt,
   output logic             wrapped,
   output logic             any
);

   logic [2*N_CH-1:0] dbl;

   always_comb begin
      // NOTE: every output gets a default before the search so no path leaves one unassigned (no latch).
      dbl     = {mask, mask};
      nxt     = '0;
      wrapped = 1'b0;
      // Descending walk: the last hit written is the lowest index in the window (cur, cur+N_CH].
      for (int i = 2*N_CH-1; i >= 0; i--) begin
         if (dbl[i] && (i > int'(cur)) && (i <= int'(cur) + N_CH)) begin
            if (i >= N_CH) begin
               nxt     = SEL_W'(i - N_CH);
               wrapped = 1'b1;
            end else begin
               nxt     = SEL_W'(i);
               wrapped = 1'b0;
            end
         end
      end
   end

   assign any = |mask;

endmodule

// File: rtl/scan_mux_n.sv
// Registered N-channel W-bit mux with manual select and masked round-robin auto-scan.
// Output reports the sampled channel, its validity and a pulse when the scan wraps.
module scan_mux_n
   import scan_mux_pkg::*;
#(
   parameter  int N_CH    = 8,
   parameter  int W       = 8,
   parameter  int DWELL_W = 8,
   localparam int SEL_W   = clog2_safe(N_CH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              mode,
   input  logic [SEL_W-1:0]  sel,
   input  logic [N_CH-1:0]   ch_mask,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [N_CH*W-1:0] din,
   output logic [W-1:0]      dout,
   output logic [SEL_W-1:0]  dout_ch,
   output logic              dout_valid,
   output logic              wrap
);

   logic [SEL_W-1:0]   cur_q, cur_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [W-1:0]       dout_q, dout_d;
   logic [SEL_W-1:0]   ch_q;
   logic               valid_q, valid_d;
   logic               wrap_q, wrap_d;

   logic [SEL_W-1:0]   s;
   logic [SEL_W-1:0]   nxt;
   logic               wrapped;
   logic               any;

   mask_rr_next #(
      .N_CH  (N_CH),
      .SEL_W (SEL_W)
   ) u_next (
      .mask    (ch_mask),
      .cur     (cur_q),
      .nxt     (nxt),
      .wrapped (wrapped),
      .any     (any)
   );

   always_comb begin
      s = (mode == MODE_SCAN) ? cur_q : sel;

      // Out-of-range indices match no channel and therefore yield zero data, invalid.
      dout_d  = '0;
      valid_d = 1'b0;
      for (int k = 0; k < N_CH; k++) begin
         if (s == SEL_W'(k)) begin
            dout_d  = din[k*W +: W];
            valid_d = ch_mask[k];
         end
      end

      cur_d  = cur_q;
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      if (mode == MODE_MANUAL) begin
         if (int'(sel) < N_CH) cur_d = sel;
         cnt_d = '0;
      end else if (!any) begin
         cnt_d = '0;
      end else if (cnt_q >= dwell) begin
         // dwell is compared live, so lowering it below the count expires at once.
         cnt_d  = '0;
         cur_d  = nxt;
         wrap_d = wrapped;
      end else begin
         cnt_d = cnt_q + DWELL_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_q   <= '0;
         cnt_q   <= '0;
         dout_q  <= '0;
         ch_q    <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else if (en) begin
         cur_q   <= cur_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         ch_q    <= s;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end else begin
         wrap_q  <= 1'b0;
      end
   end

   assign dout       = dout_q;
   assign dout_ch    = ch_q;
   assign dout_valid = valid_q;
   assign wrap       = wrap_q;

endmodule
